// File: rtl/skein_ubi_sequencer_pkg.sv
// Shared definitions for the Skein UBI sequencer and its neighbours.
//   state_t      : sequencer FSM state encoding
//   MODE_MSG/OUT : tweak-selector mode codes carried on tf_mode_o
//   SKEIN512_IV  : Skein-512-512 initial chaining value (word 0 in bits [63:0])
package skein_ubi_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MSG_GO   = 3'd1,
    ST_MSG_WAIT = 3'd2,
    ST_OUT_GO   = 3'd3,
    ST_OUT_WAIT = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  localparam logic MODE_MSG = 1'b0;
  localparam logic MODE_OUT = 1'b1;

  localparam logic [511:0] SKEIN512_IV = {
    64'hAE18A40B660FCC33, 64'h991112C71A75B523,
    64'hEABE394CA9D5C3F4, 64'h5DB62599DF6CA7B0,
    64'h9A255629FF352CB1, 64'h8FD1934127C79BCE,
    64'h0D95DE399746DF03, 64'h4903ADFF749C51CE
  };

endpackage

// File: rtl/skein_ubi_sequencer.sv
// Skein single-block hash sequencer: drives an external Threefish core through
// a message UBI pass followed by an output UBI pass.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, msg_i          hash request and 64-byte message (sampled on accept)
//   busy_o, done_o          busy from accept to done; one-cycle completion pulse
//   hash_o, hash_count_o    final hash (held), completed-hash counter (wraps)
//   tf_start_o, tf_mode_o   Threefish launch pulse; 0 = message UBI, 1 = output UBI
//   tf_key_o, tf_plain_o    Threefish key / plaintext, stable through tf_done_i
//   tf_done_i, tf_cipher_i  Threefish completion pulse and ciphertext
module skein_ubi_sequencer
  import skein_ubi_sequencer_pkg::*;
#(
  parameter int unsigned          BLOCK_W = 512,
  parameter logic [BLOCK_W-1:0]   IV      = SKEIN512_IV
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [BLOCK_W-1:0] msg_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BLOCK_W-1:0] hash_o,
  output logic [31:0]        hash_count_o,
  output logic               tf_start_o,
  output logic               tf_mode_o,
  output logic [BLOCK_W-1:0] tf_key_o,
  output logic [BLOCK_W-1:0] tf_plain_o,
  input  logic               tf_done_i,
  input  logic [BLOCK_W-1:0] tf_cipher_i
);

  state_t             state;
  logic [BLOCK_W-1:0] msg_r;

  assign busy_o = (state != ST_IDLE);

  // The Threefish-facing outputs are registered and loaded on the edge that
  // enters each GO state, so tf_start_o is high exactly during the GO cycle
  // and key/plain/mode hold until the next phase is launched. tf_key_o doubles
  // as the chaining-value register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      msg_r        <= '0;
      done_o       <= 1'b0;
      hash_o       <= '0;
      hash_count_o <= '0;
      tf_start_o   <= 1'b0;
      tf_mode_o    <= MODE_MSG;
      tf_key_o     <= '0;
      tf_plain_o   <= '0;
    end else begin
      done_o     <= 1'b0;
      tf_start_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            msg_r      <= msg_i;
            tf_start_o <= 1'b1;
            tf_mode_o  <= MODE_MSG;
            tf_key_o   <= IV;
            tf_plain_o <= msg_i;
            state      <= ST_MSG_GO;
          end
        end
        ST_MSG_GO: state <= ST_MSG_WAIT;
        ST_MSG_WAIT: begin
          if (tf_done_i) begin
            // UBI feed-forward of the message block into the chaining value
            tf_start_o <= 1'b1;
            tf_mode_o  <= MODE_OUT;
            tf_key_o   <= tf_cipher_i ^ msg_r;
            tf_plain_o <= '0;
            state      <= ST_OUT_GO;
          end
        end
        ST_OUT_GO: state <= ST_OUT_WAIT;
        ST_OUT_WAIT: begin
          if (tf_done_i) begin
            // Output plaintext is zero, so the feed-forward is the cipher itself;
            // done_o and the counter update become visible during FINISH.
            hash_o       <= tf_cipher_i;
            done_o       <= 1'b1;
            hash_count_o <= hash_count_o + 32'd1;
            state        <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skein_ubi_sequencer.sv
// Scoreboard bench for skein_ubi_sequencer with a Threefish stub whose
// ciphertext equals its key, so every hash is expected to be IV ^ msg.
module tb_skein_ubi_sequencer;
  import skein_ubi_sequencer_pkg::*;

  localparam int W = 512;

  logic         clk = 1'b0;
  logic         rst_i, start_i, busy_o, done_o, tf_start_o, tf_mode_o, tf_done_i;
  logic [W-1:0] msg_i, hash_o, tf_key_o, tf_plain_o, tf_cipher_i;
  logic [31:0]  hash_count_o;

  always #5 clk = ~clk;

  skein_ubi_sequencer #(.BLOCK_W(W), .IV(SKEIN512_IV)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .msg_i(msg_i),
    .busy_o(busy_o), .done_o(done_o), .hash_o(hash_o), .hash_count_o(hash_count_o),
    .tf_start_o(tf_start_o), .tf_mode_o(tf_mode_o), .tf_key_o(tf_key_o),
    .tf_plain_o(tf_plain_o), .tf_done_i(tf_done_i), .tf_cipher_i(tf_cipher_i)
  );

  typedef struct {
    logic [W-1:0] hash;
    logic [31:0]  cnt;
    int           lat;
    bit           chk_gap;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, done_seen = 0;
  int          cyc = 0;
  logic [31:0] exp_cnt = '0;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Threefish stub: done T cycles after the tf_start_o cycle, cipher = key.
  int           stub_lat = 3, stub_cnt = 0;
  bit           spur_req = 0;
  logic [W-1:0] spur_val = '0;

  initial begin
    tf_done_i   = 1'b0;
    tf_cipher_i = '0;
  end

  always @(negedge clk) begin
    tf_done_i = 1'b0;
    if (stub_cnt != 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        tf_done_i   = 1'b1;
        tf_cipher_i = tf_key_o;
      end
    end
    if (spur_req) begin
      tf_done_i   = 1'b1;
      tf_cipher_i = spur_val;
      spur_req    = 0;
    end
    if (tf_start_o === 1'b1) stub_cnt = stub_lat;
  end

  // Monitor: phase/key checks on launches, scoreboard pop on done_o.
  bit   exp_phase = 0, prev_busy = 0;
  int   start_cyc = 0, last_done_cyc = -100;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      exp_phase = 0;
    end else begin
      if (tf_start_o === 1'b1) begin
        check("tf_mode", W'(tf_mode_o), W'(exp_phase));
        if (exp_phase && exp_q.size() > 0) check("out_key", tf_key_o, exp_q[0].hash);
        exp_phase = ~exp_phase;
      end
      if (busy_o === 1'b1 && !prev_busy) begin
        start_cyc = cyc - 1;
        if (exp_q.size() > 0 && exp_q[0].chk_gap)
          check("idle_gap", W'(start_cyc - last_done_cyc), W'(1));
      end
      if (done_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done_o=1 expected no completion");
        end else begin
          mon_e = exp_q.pop_front();
          check("hash", hash_o, mon_e.hash);
          check("count", W'(hash_count_o), W'(mon_e.cnt));
          check("latency", W'(cyc - start_cyc + 1), W'(mon_e.lat));
        end
        last_done_cyc = cyc;
        done_seen++;
      end
    end
    prev_busy = (busy_o === 1'b1);
  end

  task automatic push_exp(input logic [W-1:0] m, input int lat, input bit gap);
    exp_t e;
    exp_cnt++;
    e.hash    = SKEIN512_IV ^ m;
    e.cnt     = exp_cnt;
    e.lat     = 2 * lat + 4;
    e.chk_gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (done_seen < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_seen < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d completions expected %0d", name, done_seen, target);
      exp_q.delete();
    end
  endtask

  task automatic do_hash(input logic [W-1:0] m, input int lat, input bit spur_go);
    int target;
    stub_lat = lat;
    wait_idle();
    push_exp(m, lat, 0);
    target  = done_seen + 1;
    start_i = 1'b1;
    msg_i   = m;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    msg_i   = ~m;
    if (spur_go) begin
      spur_val = {16{$urandom}};
      spur_req = 1;
    end
    wait_done(target, "hash");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  W'(busy_o), '0);
    check({tag, "_done"},  W'(done_o), '0);
    check({tag, "_start"}, W'(tf_start_o), '0);
    check({tag, "_mode"},  W'(tf_mode_o), '0);
    check({tag, "_key"},   tf_key_o, '0);
    check({tag, "_plain"}, tf_plain_o, '0);
    check({tag, "_hash"},  hash_o, '0);
    check({tag, "_count"}, W'(hash_count_o), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  logic [W-1:0] pat_a, pat_b, pat_c, pat_d;
  int           t, target;

  initial begin
    pat_a   = {8{64'hA5A5_5A5A_0F0F_F0F0}};
    pat_b   = {16{32'h1234_5678}};
    pat_c   = {8{64'hDEAD_BEEF_0000_FFFF}};
    pat_d   = {64{8'h3C}};
    rst_i   = 1'b1;
    start_i = 1'b0;
    msg_i   = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk);

    // Basic hashes: zero message, then all-ones message.
    do_hash('0, 3, 0);
    do_hash('1, 3, 0);

    // start held high: two back-to-back hashes, one IDLE cycle between.
    stub_lat = 3;
    wait_idle();
    push_exp(pat_a, 3, 0);
    push_exp(pat_a, 3, 1);
    target  = done_seen + 2;
    start_i = 1'b1;
    msg_i   = pat_a;
    wait_done(target, "held");
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    check("held_no_third", W'(busy_o), '0);

    // Spurious tf_done_i while idle.
    @(posedge clk);
    #1;
    spur_val = {16{$urandom}};
    spur_req = 1;
    repeat (3) @(negedge clk);
    check("spur_idle_busy", W'(busy_o), '0);
    check("spur_idle_hash", hash_o, SKEIN512_IV ^ pat_a);
    check("spur_idle_count", W'(hash_count_o), W'(exp_cnt));

    // Spurious tf_done_i in MSG_GO plus one-cycle core latency.
    do_hash(pat_b, 1, 1);

    // Reset during OUT_WAIT, then a late tf_done_i from the core.
    stub_lat = 3;
    wait_idle();
    push_exp(pat_c, 3, 0);
    start_i = 1'b1;
    msg_i   = pat_c;
    @(negedge clk);
    start_i = 1'b0;
    t = 0;
    while (!(busy_o === 1'b1 && tf_mode_o === 1'b1 && tf_start_o === 1'b0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reach_out_wait", W'(t < 50), W'(1));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    check_all_zero("midreset");
    repeat (4) @(negedge clk);
    check("late_done_busy", W'(busy_o), '0);
    check("late_done_hash", hash_o, '0);
    check("late_done_count", W'(hash_count_o), '0);

    // Recovery after the abandoned hash.
    do_hash(pat_c, 3, 0);

    // Counter wrap from all-ones.
    wait_idle();
    force dut.hash_count_o = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.hash_count_o;
    exp_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("preload_count", W'(hash_count_o), W'(32'hFFFF_FFFF));
    do_hash(pat_d, 2, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skein_ubi_sequencer.md
SKEIN_UBI_SEQUENCER -- requirements
Module: skein_ubi_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_W, default 512, width of state/message/key/hash words in bits.
REQ-002 SHALL have parameter IV, default SKEIN512_IV from the shared package, initial chaining value.
REQ-003 SHALL provide these ports:
  - clk_i  input  1  sole clock; all state updates on rising edge.
  - rst_i  input  1  reset, synchronous and active-high.
  - start_i  input  1  request to hash msg_i.
  - msg_i  input  BLOCK_W  64-byte message, sampled only on an accepted start.
  - busy_o  output  1  high from accepted start until done_o.
  - done_o  output  1  one-cycle pulse when hash_o becomes valid.
  - hash_o  output  BLOCK_W  final hash, held until the next accepted start.
  - hash_count_o  output  32  completed-hash counter.
  - tf_start_o  output  1  one-cycle pulse launching the Threefish core.
  - tf_mode_o  output  1  to tweak selector mode: 0 = message UBI, 1 = output UBI.
  - tf_key_o  output  BLOCK_W  Threefish key (chaining value).
  - tf_plain_o  output  BLOCK_W  Threefish plaintext.
  - tf_done_i  input  1  one-cycle pulse from the Threefish core; result valid on tf_cipher_i.
  - tf_cipher_i  input  BLOCK_W  Threefish ciphertext.

Function
REQ-004 SHALL implement FSM states IDLE, MSG_GO, MSG_WAIT, OUT_GO, OUT_WAIT, FINISH.
REQ-005 SHALL accept start_i only in IDLE: latch msg_i into msg_r, load chain_r <= IV, go to MSG_GO; start_i in any other state is ignored.
REQ-006 In MSG_GO SHALL assert tf_start_o for exactly one cycle with tf_mode_o=0, tf_key_o=chain_r, tf_plain_o=msg_r, then go to MSG_WAIT.
REQ-007 In MSG_WAIT on tf_done_i SHALL load chain_r <= tf_cipher_i XOR msg_r (UBI feed-forward) and go to OUT_GO.
REQ-008 In OUT_GO SHALL pulse tf_start_o for one cycle with tf_mode_o=1, tf_key_o=chain_r, tf_plain_o=0, then go to OUT_WAIT.
REQ-009 In OUT_WAIT on tf_done_i SHALL load hash_o <= tf_cipher_i (XOR zero plaintext) and go to FINISH.
REQ-010 In FINISH SHALL pulse done_o for one cycle, increment hash_count_o (wrap 0xFFFFFFFF→0), and return to IDLE.
REQ-011 tf_mode_o, tf_key_o and tf_plain_o SHALL stay stable from the GO cycle through the matching tf_done_i.
REQ-012 tf_done_i SHALL be ignored in IDLE, MSG_GO, OUT_GO and FINISH.
REQ-013 busy_o SHALL be high in every state except IDLE; start_i is accepted again the cycle after done_o.
REQ-014 Latency from accepted start to done_o SHALL be 2 + T1 + 1 + T2 + 1 cycles, where Tn = tf_start_o-to-tf_done_i cycles of phase n.
REQ-015 tf_done_i arriving in the cycle immediately after tf_start_o SHALL be honoured; the sequencer tolerates T=1.

Reset
REQ-016 On rst_i SHALL enter IDLE and clear busy_o, done_o, tf_start_o, tf_mode_o, tf_key_o, tf_plain_o, hash_o and hash_count_o to 0.
REQ-017 Reset mid-operation SHALL abandon the hash with no done_o; a late tf_done_i after reset SHALL be ignored.
REQ-018 rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-019 The shared package SHALL hold the FSM state encoding, SKEIN512_IV, and the mode constants MODE_MSG=0 and MODE_OUT=1 (shared with the tweak selector).
REQ-020 The block SHALL be a single module with no sub-modules; the tweak selector and Threefish core are instantiated by the parent and wired through tf_mode_o.

Verification (Threefish stub: tf_cipher_i = tf_key_o, done after 3 cycles)
REQ-021 Reset, then start with msg_i=0 → one tf_start_o with mode 0, then one with mode 1; hash_o=IV; done_o 10 cycles after start; hash_count_o=1.
REQ-022 msg_i=all-ones → hash_o = IV XOR all-ones; tf_key_o in the OUT phase equals the same value.
REQ-023 Hold start_i high continuously → hashes back-to-back with exactly one IDLE cycle between them; mid-run starts are ignored; count increments once per done_o.
REQ-024 Spurious tf_done_i in IDLE and in MSG_GO → no state change; stub latency of 1 cycle → correct hash.
REQ-025 Assert rst_i during OUT_WAIT, then deliver a late tf_done_i → no done_o, all outputs 0; a following start completes correctly.
REQ-026 Preload hash_count_o to 0xFFFFFFFF by forced run → next completion reads 0.
